// File: rtl/iprf.sv
// Integer physical register file: 1-cycle read ports with same-cycle write-back
// bypass, multi-port write-back, and a per-entry ready scoreboard fed by rename.

package iprf_pkg;
    localparam int PRF_ID_W        = 6;
    localparam int RV_XLEN         = 32;
    localparam int IPRF_NUM_WRITES = 2;

    typedef logic [PRF_ID_W-1:0] t_prf_id;
    typedef logic [RV_XLEN-1:0]  t_rv_reg_data;

    typedef struct packed {
        t_prf_id      pdst;
        t_rv_reg_data data;
    } t_prf_wr_pkt;

`ifdef SIMULATION
    function automatic string f_describe_prf(t_prf_id id);
        return $sformatf("p%0d", id);
    endfunction
`endif
endpackage

// One read port plus its scoreboard query; both see the ro0 write-back bus
// so a producer writing this cycle is visible to a consumer reading this cycle.
module iprf_rd_lane
    import iprf_pkg::*;
#(
    parameter int NUM_ENTS     = 64,
    parameter int NUM_WR_PORTS = IPRF_NUM_WRITES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rden,
    input  t_prf_id                             addr,
    input  t_rv_reg_data [NUM_ENTS-1:0]         mem,
    input  logic         [NUM_ENTS-1:0]         rdy,
    input  logic         [NUM_WR_PORTS-1:0]     wr_en,
    input  t_prf_wr_pkt  [NUM_WR_PORTS-1:0]     wr_pkt,
    input  t_prf_id                             qry_id,
    output t_rv_reg_data                        rddata,
    output logic                                qry_rdy
);
    logic         byp_hit;
    t_rv_reg_data byp_data;
    logic         qry_hit;
    t_rv_reg_data rd_val;

    // Later ports overwrite earlier ones, so the highest hitting index wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        qry_hit  = 1'b0;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_en[w] && wr_pkt[w].pdst == addr) begin
                byp_hit  = 1'b1;
                byp_data = wr_pkt[w].data;
            end
            if (wr_en[w] && wr_pkt[w].pdst == qry_id && wr_pkt[w].pdst != '0)
                qry_hit = 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        if (rden && addr != '0)
            rd_val = byp_hit ? byp_data : mem[addr];
    end

    assign qry_rdy = rdy[qry_id] | qry_hit;

    always_ff @(posedge clk) begin
        if (reset) rddata <= '0;
        else       rddata <= rd_val;
    end
endmodule

module iprf
    import iprf_pkg::*;
#(
    parameter int    NUM_ENTS     = 64,
    parameter int    NUM_RD_PORTS = 2,
    parameter int    NUM_WR_PORTS = IPRF_NUM_WRITES,
    parameter int    NUM_ALLOC    = 1,
    parameter string RF_NAME      = ""
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic         [NUM_RD_PORTS-1:0]     prf_rdens_rd0,
    input  t_prf_id      [NUM_RD_PORTS-1:0]     prf_rdaddrs_rd0,
    output t_rv_reg_data [NUM_RD_PORTS-1:0]     prf_rddatas_rd1,
    input  logic         [NUM_WR_PORTS-1:0]     iprf_wr_en_ro0,
    input  t_prf_wr_pkt  [NUM_WR_PORTS-1:0]     iprf_wr_pkt_ro0,
    input  logic         [NUM_ALLOC-1:0]        alloc_en_rn0,
    input  t_prf_id      [NUM_ALLOC-1:0]        alloc_pdst_rn0,
    input  t_prf_id      [NUM_RD_PORTS-1:0]     rdy_qry_ids,
    output logic         [NUM_RD_PORTS-1:0]     rdy_qry_rdy
);
    if (NUM_ENTS != (1 << $bits(t_prf_id))) begin : g_bad_ents
        $error("iprf %s: NUM_ENTS must equal 2**$bits(t_prf_id)", RF_NAME);
    end

    t_rv_reg_data [NUM_ENTS-1:0] mem;
    logic         [NUM_ENTS-1:0] rdy;

    // Entry 0 is never written or allocated, so it holds its reset value
    // (data 0, ready 1) forever. Alloc is applied after write-back so a
    // same-cycle alloc leaves the entry not-ready for its new producer.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
            rdy <= '1;
        end else begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (iprf_wr_en_ro0[w] && iprf_wr_pkt_ro0[w].pdst != '0) begin
                    mem[iprf_wr_pkt_ro0[w].pdst] <= iprf_wr_pkt_ro0[w].data;
                    rdy[iprf_wr_pkt_ro0[w].pdst] <= 1'b1;
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_en_rn0[a] && alloc_pdst_rn0[a] != '0)
                    rdy[alloc_pdst_rn0[a]] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_lane
        iprf_rd_lane #(
            .NUM_ENTS     (NUM_ENTS),
            .NUM_WR_PORTS (NUM_WR_PORTS)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .rden    (prf_rdens_rd0[p]),
            .addr    (prf_rdaddrs_rd0[p]),
            .mem     (mem),
            .rdy     (rdy),
            .wr_en   (iprf_wr_en_ro0),
            .wr_pkt  (iprf_wr_pkt_ro0),
            .qry_id  (rdy_qry_ids[p]),
            .rddata  (prf_rddatas_rd1[p]),
            .qry_rdy (rdy_qry_rdy[p])
        );
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_RD_PORTS; p++)
                assert (!$isunknown(prf_rdens_rd0[p]))
                    else $error("iprf %s: rden[%0d] is X", RF_NAME, p);
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (iprf_wr_en_ro0[w])
                    $info("iprf %s: write %s = %h", RF_NAME,
                          f_describe_prf(iprf_wr_pkt_ro0[w].pdst), iprf_wr_pkt_ro0[w].data);
                for (int v = w + 1; v < NUM_WR_PORTS; v++)
                    assert (!(iprf_wr_en_ro0[w] && iprf_wr_en_ro0[v] &&
                              iprf_wr_pkt_ro0[w].pdst == iprf_wr_pkt_ro0[v].pdst &&
                              iprf_wr_pkt_ro0[w].pdst != '0))
                        else $error("iprf %s: write ports %0d/%0d collide on %s", RF_NAME, w, v,
                                    f_describe_prf(iprf_wr_pkt_ro0[w].pdst));
            end
        end
    end
`endif
endmodule

// File: tb/tb_iprf.sv
// Scoreboard bench for iprf: expected read data is queued when a request is
// driven and popped when the registered result appears one cycle later.
module tb_iprf;
    import iprf_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic         [1:0]     rdens;
    t_prf_id      [1:0]     rdaddrs;
    t_rv_reg_data [1:0]     rddatas;
    logic         [1:0]     wr_en;
    t_prf_wr_pkt  [1:0]     wr_pkt;
    logic         [0:0]     alloc_en;
    t_prf_id      [0:0]     alloc_pdst;
    t_prf_id      [1:0]     qry_ids;
    logic         [1:0]     qry_rdy;

    iprf dut (
        .clk             (clk),
        .reset           (reset),
        .prf_rdens_rd0   (rdens),
        .prf_rdaddrs_rd0 (rdaddrs),
        .prf_rddatas_rd1 (rddatas),
        .iprf_wr_en_ro0  (wr_en),
        .iprf_wr_pkt_ro0 (wr_pkt),
        .alloc_en_rn0    (alloc_en),
        .alloc_pdst_rn0  (alloc_pdst),
        .rdy_qry_ids     (qry_ids),
        .rdy_qry_rdy     (qry_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        t_rv_reg_data d0;
        t_rv_reg_data d1;
        string        nm;
    } t_exp;

    t_exp         sb[$];
    int           n_pass = 0;
    int           n_total = 0;
    t_rv_reg_data ref_mem [64];
    logic         ref_rdy [64];

    task automatic idle();
        rdens = '0; rdaddrs = '0; wr_en = '0; wr_pkt = '0;
        alloc_en = '0; alloc_pdst = '0; qry_ids = '0;
    endtask

    task automatic wr(input int port, input t_prf_id pdst, input t_rv_reg_data d);
        wr_en[port] = 1'b1;
        wr_pkt[port].pdst = pdst;
        wr_pkt[port].data = d;
    endtask

    task automatic rd(input int port, input logic en, input t_prf_id a);
        rdens[port] = en;
        rdaddrs[port] = a;
    endtask

    task automatic qry(input t_prf_id a0, input t_prf_id a1, input logic [1:0] exp, input string nm);
        qry_ids[0] = a0; qry_ids[1] = a1;
        #1;
        n_total++;
        if (qry_rdy !== exp) $display("FAIL %s: rdy_qry_rdy got %b want %b", nm, qry_rdy, exp);
        else n_pass++;
    endtask

    // Push the expected rd1 data for the inputs now driven, clock once, and
    // pop/compare against the registered outputs.
    task automatic cyc(input t_rv_reg_data e0, input t_rv_reg_data e1, input string nm);
        t_exp e;
        e.d0 = e0; e.d1 = e1; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_total++;
        if (rddatas[0] !== e.d0) $display("FAIL %s port0: got %h want %h", e.nm, rddatas[0], e.d0);
        else n_pass++;
        n_total++;
        if (rddatas[1] !== e.d1) $display("FAIL %s port1: got %h want %h", e.nm, rddatas[1], e.d1);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        cyc(0, 0, "reset0");
        cyc(0, 0, "reset1");
        reset = 1'b0;
        rd(0, 1'b1, 6'd5); rd(1, 1'b1, 6'd63);
        qry(6'd5, 6'd63, 2'b11, "reset_rdy");
        cyc(0, 0, "reset_read");
    endtask

    task automatic test_write_read();
        idle();
        wr(0, 6'd7, 32'hDEAD_BEEF);
        cyc(0, 0, "wr7_norden");
        idle();
        rd(0, 1'b1, 6'd7); rd(1, 1'b1, 6'd7);
        cyc(32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd7");
    endtask

    task automatic test_bypass();
        idle();
        alloc_en[0] = 1'b1; alloc_pdst[0] = 6'd9;
        cyc(0, 0, "alloc9");
        idle();
        qry(6'd9, 6'd9, 2'b00, "rdy9_alloc");
        wr(0, 6'd9, 32'h1234);
        rd(0, 1'b1, 6'd9); rd(1, 1'b1, 6'd9);
        qry(6'd9, 6'd9, 2'b11, "rdy9_bypass");
        cyc(32'h1234, 32'h1234, "bypass9");
        idle();
        qry(6'd9, 6'd7, 2'b11, "rdy9_after");
    endtask

    task automatic test_zero();
        idle();
        wr(0, 6'd0, 32'hFFFF); wr(1, 6'd0, 32'hFFFF);
        rd(0, 1'b1, 6'd0); rd(1, 1'b1, 6'd0);
        cyc(0, 0, "zero_bypass");
        idle();
        rd(0, 1'b1, 6'd0); rd(1, 1'b1, 6'd0);
        alloc_en[0] = 1'b1; alloc_pdst[0] = 6'd0;
        cyc(0, 0, "zero_read");
        idle();
        qry(6'd0, 6'd0, 2'b11, "zero_rdy");
    endtask

    task automatic test_alloc();
        idle();
        alloc_en[0] = 1'b1; alloc_pdst[0] = 6'd12;
        cyc(0, 0, "alloc12");
        idle();
        qry(6'd12, 6'd13, 2'b10, "rdy12_n1");
        cyc(0, 0, "alloc12_gap1");
        qry(6'd13, 6'd12, 2'b01, "rdy12_n2");
        cyc(0, 0, "alloc12_gap2");
        wr(1, 6'd12, 32'h55);
        cyc(0, 0, "wr12");
        idle();
        qry(6'd12, 6'd12, 2'b11, "rdy12_written");
        wr(0, 6'd12, 32'h77);
        alloc_en[0] = 1'b1; alloc_pdst[0] = 6'd12;
        cyc(0, 0, "alloc_wr12");
        idle();
        qry(6'd12, 6'd12, 2'b00, "rdy12_alloc_wins");
        rd(0, 1'b1, 6'd12); rd(1, 1'b1, 6'd7);
        cyc(32'h77, 32'hDEAD_BEEF, "rd12_data");
    endtask

    task automatic test_dual_write();
        idle();
        wr(0, 6'd20, 32'hA); wr(1, 6'd20, 32'hB);
        cyc(0, 0, "dual_wr20");
        idle();
        rd(0, 1'b1, 6'd20); rd(1, 1'b0, 6'd20);
        cyc(32'hB, 0, "rd20_rden0");
        wr(0, 6'd21, 32'hC); wr(1, 6'd21, 32'hD);
        rd(0, 1'b1, 6'd21); rd(1, 1'b1, 6'd21);
        cyc(32'hD, 32'hD, "dual_bypass21");
        idle();
    endtask

    task automatic test_reset_midstream();
        idle();
        rd(0, 1'b1, 6'd7); rd(1, 1'b1, 6'd21);
        cyc(32'hDEAD_BEEF, 32'hD, "pre_reset");
        reset = 1'b1;
        wr(0, 6'd30, 32'h99);
        alloc_en[0] = 1'b1; alloc_pdst[0] = 6'd5;
        cyc(0, 0, "in_reset");
        reset = 1'b0;
        idle();
        rd(0, 1'b1, 6'd30); rd(1, 1'b1, 6'd7);
        qry(6'd5, 6'd12, 2'b11, "rdy_after_reset");
        cyc(0, 0, "post_reset");
    endtask

    task automatic test_back_to_back();
        t_rv_reg_data e [2];
        logic [1:0]   qe;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            ref_rdy[i] = 1'b1;
        end
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int w = 0; w < 2; w++)
                if ($urandom_range(0, 1) == 1) wr(w, t_prf_id'($urandom_range(0, 15)), $urandom);
            if (wr_en == 2'b11 && wr_pkt[0].pdst == wr_pkt[1].pdst) wr_en[0] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                alloc_en[0] = 1'b1;
                alloc_pdst[0] = t_prf_id'($urandom_range(0, 15));
            end
            for (int p = 0; p < 2; p++) begin
                rd(p, 1'($urandom_range(0, 3) != 0), t_prf_id'($urandom_range(0, 15)));
                qry_ids[p] = t_prf_id'($urandom_range(0, 15));
                e[p] = (rdens[p] && rdaddrs[p] != 0) ? ref_mem[rdaddrs[p]] : '0;
                qe[p] = ref_rdy[qry_ids[p]];
                for (int w = 0; w < 2; w++) begin
                    if (wr_en[w] && wr_pkt[w].pdst != 0) begin
                        if (rdens[p] && wr_pkt[w].pdst == rdaddrs[p]) e[p] = wr_pkt[w].data;
                        if (wr_pkt[w].pdst == qry_ids[p]) qe[p] = 1'b1;
                    end
                end
            end
            qry(qry_ids[0], qry_ids[1], qe, "rand_rdy");
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_pkt[w].pdst != 0) begin
                    ref_mem[wr_pkt[w].pdst] = wr_pkt[w].data;
                    ref_rdy[wr_pkt[w].pdst] = 1'b1;
                end
            if (alloc_en[0] && alloc_pdst[0] != 0) ref_rdy[alloc_pdst[0]] = 1'b0;
            cyc(e[0], e[1], "rand_rd");
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_alloc();
        test_dual_write();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/iprf.md
# iprf

Integer physical register file: the responder end of the RS-to-PRF read interface and the sink of the execution write-back (ro0) bus. It stores one `t_rv_reg_data` per physical register, serves NUM_RD_PORTS read requests with fixed one-cycle latency (request in rd0, data in rd1), and accepts IPRF_NUM_WRITES write-backs per cycle. It also keeps a per-entry ready scoreboard: rename clears a bit on pdst allocation, and write-back sets it. Rename and the RS use the scoreboard for source readiness.

## Interface
- NUM_ENTS, default 64: physical registers; must equal 2**$bits(t_prf_id).
- NUM_RD_PORTS, default 2: read ports; one RS instance uses [1:0].
- NUM_WR_PORTS, default IPRF_NUM_WRITES: write-back ports.
- NUM_ALLOC, default 1: rename allocation ports per cycle.
- RF_NAME, default "": debug string.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- prf_rdens_rd0  in  [NUM_RD_PORTS-1:0]x1  read enable per port.
- prf_rdaddrs_rd0  in  [NUM_RD_PORTS-1:0] t_prf_id  read address.
- prf_rddatas_rd1  out  [NUM_RD_PORTS-1:0] t_rv_reg_data  read data, one cycle after request.
- iprf_wr_en_ro0  in  [NUM_WR_PORTS-1:0]x1  write enable.
- iprf_wr_pkt_ro0  in  [NUM_WR_PORTS-1:0] t_prf_wr_pkt  fields pdst (t_prf_id) and data (t_rv_reg_data).
- alloc_en_rn0  in  [NUM_ALLOC-1:0]x1  rename allocating a new pdst.
- alloc_pdst_rn0  in  [NUM_ALLOC-1:0] t_prf_id  allocated entry.
- rdy_qry_ids  in  [NUM_RD_PORTS-1:0] t_prf_id  scoreboard query address.
- rdy_qry_rdy  out  [NUM_RD_PORTS-1:0]x1  combinational ready result for the query.

## Operation
- Storage: NUM_ENTS x t_rv_reg_data flops, plus a ready vector of NUM_ENTS bits.
- Entry 0 is the hardwired zero register.
  - Reads of entry 0 always return 0.
  - Writes to entry 0 are dropped.
  - Ready bit 0 is constantly 1; allocations of entry 0 are ignored.
- Write: on posedge, for each port with wr_en and pdst != 0, set mem[pdst] = data and rdy[pdst] = 1.
- Multiple write ports to the same pdst in one cycle:
  - Highest port index wins.
  - A SIMULATION assertion fires; this is illegal upstream.
- Read: for each port p, at rd0 the value is computed as follows, then registered into prf_rddatas_rd1[p]:
  - if rden = 0: 0
  - if addr = 0: 0
  - if a same-cycle ro0 write hits addr: the write data (highest-index hitting port)
  - otherwise: mem[addr]
- The same-cycle write-to-read bypass is mandatory. The RS reads at rd0 in the same cycle a producer writes back.
- Read ports are independent; two ports may read the same address.
- Allocation: on posedge, alloc_en with pdst != 0 clears rdy[pdst]. Data is untouched.
- Alloc and write-back to the same pdst in the same cycle: alloc wins and rdy ends at 0, because the entry now belongs to a new producer.
- Scoreboard query: rdy_qry_rdy[p] = rdy[id] | (some ro0 write hits id this cycle). The bypass mirrors the read path.
- SIMULATION debug:
  - UINFO on every write, printing RF_NAME, f_describe_prf(pdst) and data.
  - Assert that no rden is X while out of reset.

## Timing
- Read latency is exactly 1 cycle: request in rd0 at cycle N gives data valid at cycle N+1.
- There is no stall or backpressure; every request is served.
- Writes are visible to a non-bypassed read the cycle after the write.
- Allocation takes effect the next cycle.
- Reset, synchronous:
  - mem all 0.
  - rdy all 1 (architectural state is initially clean).
  - prf_rddatas_rd1 all 0.
- Reset asserted mid-stream: reads requested in the reset cycle return 0 the following cycle, and writes and allocs in a reset cycle are discarded.
- The first cycle after reset deasserts is fully functional.

## Test plan
- Reset, then read entries 5 and 63 on ports 0/1 -> rd1 data 0/0; rdy_qry for 5 returns 1.
- Write port0 pdst=7 data=0xDEAD_BEEF at cycle N; read 7 at N+1 -> 0xDEAD_BEEF at N+2.
- Same-cycle write pdst=9 data=0x1234 and read 9 on both ports -> both ports return 0x1234 next cycle; rdy_qry(9) = 1 in that cycle.
- Write pdst=0 data=0xFFFF then read 0 -> 0; alloc pdst=0 -> rdy_qry(0) stays 1.
- Alloc pdst=12 at N -> rdy_qry(12) = 0 at N+1; write 12 at N+3 -> rdy = 1 at N+4.
  - Alloc and write 12 in the same cycle -> rdy = 0 afterwards.
- Two write ports both to pdst=20 with data 0xA and 0xB (port1) -> read returns 0xB and the assertion fires.
  - rden = 0 with addr=20 -> data 0.
